// File: rtl/registro_pkg.sv
// registro_pkg: shared mode and state encodings for registro_universal
package registro_pkg;
  typedef enum logic [2:0] {
    MODE_SHL = 3'b000,
    MODE_SHR = 3'b001,
    MODE_SAR = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100,
    MODE_SIL = 3'b101,
    MODE_SIR = 3'b110,
    MODE_NOP = 3'b111
  } mode_t;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/registro_paso.sv
// registro_paso: one combinational 1-bit shift/rotate step with the bit that leaves the word
module registro_paso
  import registro_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] d,
  input  mode_t        mode,
  input  logic         serial_in,
  output logic [W-1:0] q,
  output logic         out_bit
);
  // left modes drop the MSB, right modes drop the LSB; NOP leaves the word alone
  always_comb begin
    q = d;
    out_bit = 1'b0;
    case (mode)
      MODE_SHL: begin q = {d[W-2:0], 1'b0};      out_bit = d[W-1]; end
      MODE_SHR: begin q = {1'b0, d[W-1:1]};      out_bit = d[0];   end
      MODE_SAR: begin q = {d[W-1], d[W-1:1]};    out_bit = d[0];   end
      MODE_ROL: begin q = {d[W-2:0], d[W-1]};    out_bit = d[W-1]; end
      MODE_ROR: begin q = {d[0], d[W-1:1]};      out_bit = d[0];   end
      MODE_SIL: begin q = {d[W-2:0], serial_in}; out_bit = d[W-1]; end
      MODE_SIR: begin q = {serial_in, d[W-1:1]}; out_bit = d[0];   end
      default:  begin q = d;                     out_bit = 1'b0;   end
    endcase
  end
endmodule

// File: rtl/registro_universal.sv
// registro_universal: parallel-load register with multi-cycle shift/rotate and start/busy/done handshake; REGISTRO_UNIVERSAL_ABORT_EN adds an abort input
module registro_universal
  import registro_pkg::*;
#(
  parameter int REGISTER_WIDTH = 16,
  parameter int AMOUNT_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [REGISTER_WIDTH-1:0] i_data,
  input  logic                      start,
  input  logic [2:0]                mode,
  input  logic [AMOUNT_WIDTH-1:0]   amount,
  input  logic                      serial_in,
`ifdef REGISTRO_UNIVERSAL_ABORT_EN
  input  logic                      abort,
`endif
  output logic [REGISTER_WIDTH-1:0] o_data,
  output logic                      serial_out,
  output logic                      busy,
  output logic                      done
);
  state_t                    state_q, state_d;
  mode_t                     mode_q, mode_d;
  logic [REGISTER_WIDTH-1:0] data_q, data_d, step_data;
  logic [AMOUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                      busy_q, busy_d, sout_q, sout_d, step_out, abort_i;

`ifdef REGISTRO_UNIVERSAL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  registro_paso #(.W(REGISTER_WIDTH)) u_paso (
    .d        (data_q),
    .mode     (mode_q),
    .serial_in(serial_in),
    .q        (step_data),
    .out_bit  (step_out)
  );

  // next-state: load or accept a start in IDLE, one step per cycle in SHIFT, single DONE cycle
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    sout_d  = sout_q;
    case (state_q)
      ST_IDLE: begin
        if (we) begin
          data_d = i_data;
        end else if (start) begin
          mode_d  = mode_t'(mode);
          cnt_d   = amount;
          busy_d  = amount != '0;
          state_d = amount != '0 ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (abort_i) begin
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          data_d = step_data;
          sout_d = mode_q == MODE_NOP ? sout_q : step_out;
          cnt_d  = cnt_q - AMOUNT_WIDTH'(1);
          if (cnt_q == AMOUNT_WIDTH'(1)) begin
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state register with synchronous active-low reset discarding any partial result
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SHL;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      sout_q  <= sout_d;
    end
  end

  assign o_data     = data_q;
  assign serial_out = sout_q;
  assign busy       = busy_q;
  assign done       = state_q == ST_DONE;
endmodule

// File: doc/registro_universal.md
Name: registro_universal

Overview:
- Parametrised successor to the team's PIPO register.
- Keeps the single-cycle parallel load and adds multi-cycle shift/rotate operations of programmable length, serial in/out and a start/busy/done handshake.
- Used as a general datapath register and as the serialiser/deserialiser stage in later lab experiments.

Parameters:
- REGISTER_WIDTH, 16, data width in bits (>= 2).
- AMOUNT_WIDTH, 5, width of the shift-amount input; maximum amount is 2**AMOUNT_WIDTH-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- we  in  1  parallel load request.
- i_data  in  REGISTER_WIDTH  parallel load data.
- start  in  1  begin shift operation.
- mode  in  3  operation select, sampled with start.
- amount  in  AMOUNT_WIDTH  number of one-bit steps, sampled with start.
- serial_in  in  1  fill bit for serial modes, sampled each step.
- o_data  out  REGISTER_WIDTH  register contents.
- serial_out  out  1  last bit shifted/rotated out.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0 at a rising edge): o_data=0, serial_out=0, busy=0, done=0, state=IDLE. Reset overrides everything, including an operation in progress. Any partial shift result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE + we=1: o_data<=i_data at that edge; state stays IDLE. we has priority over start on the same edge; start is ignored.
- IDLE + start=1, we=0:
  - Latch mode and amount into a step counter.
  - busy<=1, next state SHIFT.
  - If amount=0: next state DONE directly and busy stays 0.
- SHIFT: each edge performs one 1-bit step and decrements the counter. After the step with counter==1, busy<=0 and next state DONE.
- DONE: done=1 for exactly this cycle; next state IDLE.
- Latency: start accepted at edge k, amount N>0. Steps occur at edges k+1..k+N. busy is high from edge k to edge k+N. done is high for the cycle after edge k+N. A new start is accepted no earlier than edge k+N+2.
- we and start are ignored in SHIFT and DONE; no queuing.
- Modes, one step each:
  - 000 logical left, fill 0.
  - 001 logical right, fill 0.
  - 010 arithmetic right, MSB replicated.
  - 011 rotate left.
  - 100 rotate right.
  - 101 left with serial_in into the LSB.
  - 110 right with serial_in into the MSB.
  - 111 reserved: step counter runs and data is held unchanged.
- serial_out <= the bit leaving the register on each step (MSB for left modes, LSB for right modes); it holds between operations.
- Amounts >= REGISTER_WIDTH are not clamped. Logical shifts saturate to 0; rotates wrap modulo REGISTER_WIDTH.
- Inputs mode and amount are don't-care except on the start edge.

Optional Feature:
- Macro: REGISTRO_UNIVERSAL_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in SHIFT finishes the operation at that edge: no step performed, busy<=0, next state DONE, done pulses normally, o_data keeps its partial result. abort in IDLE or DONE is ignored.
- Undefined: port absent; operations always run to completion.

Decomposition:
- Package registro_pkg:
  - mode encodings MODE_SHL, MODE_SHR, MODE_SAR, MODE_ROL, MODE_ROR, MODE_SIL, MODE_SIR, MODE_NOP.
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One sub-module: registro_paso, purely combinational. Inputs are data, mode and serial_in; outputs are the next data word and the out-bit. The top holds the FSM, counter and register.

Test Plan (REGISTER_WIDTH=16):
- Reset then load: rst=0 for 2 cycles, then we=1, i_data=16'hA5C3 → o_data=0 during reset, 16'hA5C3 one edge after we, busy=0, done=0.
- Logical left: from 16'hA5C3, start with mode=000, amount=4 → busy high 4 cycles, o_data=16'h5C30, serial_out=0, done high exactly one cycle.
- Arithmetic and serial: load 16'h8000, SAR amount=3 → 16'hF000. Then mode=110 with serial_in=1 and amount=2 → 16'hFC00, serial_out=0.
- Rotate wrap: load 16'h0001, mode=100, amount=20 → o_data=16'h1000, busy 20 cycles. A mid-operation we=1, i_data=16'hFFFF is ignored.
- Boundaries:
  - amount=0 → done one cycle after the start edge, data unchanged, busy never high.
  - we and start on the same edge → load only.
  - rst=0 during step 2 of an amount=8 shift → o_data=0, IDLE, no done pulse.
- With REGISTRO_UNIVERSAL_ABORT_EN: SHL amount=8 on 16'h00FF, abort during the 3rd SHIFT cycle → o_data=16'h03FC, done pulses once, busy drops at the abort edge.
